instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Front-end fetch stage. Owns the PC and issues word-aligned requests to instruction memory.
//  Buffers in-order responses in a small fetch queue and presents (pc, instr) pairs to decode.
//  Consumes the next-address redirect produced by the branch/jump resolution logic (iaddr side).
//  Sits between the imem port and the decode stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  FQ_DEPTH   2              fetch-queue entries; also the cap on outstanding + buffered requests (power of 2, >=2)
// PORTS
//  clk               in   1   clock, rising edge
//  rst_n             in   1   asynchronous active-low reset
//  redirect_valid    in   1   branch/jump resolved to a non-sequential target this cycle
//  redirect_addr     in   32  target address (the branch unit's iaddr)
//  imem_req_valid    out  1   fetch request valid
//  imem_req_ready    in   1   imem accepts request
//  imem_req_addr     out  32  word address to fetch (bits[1:0] always 0)
//  imem_rsp_valid    in   1   response data valid; responses return in request order, no backpressure
//  imem_rsp_data     in   32  instruction word
//  if_valid          out  1   fetch-queue head valid to decode
//  if_ready          in   1   decode accepts head
//  if_pc             out  32  PC of head instruction
//  if_instr          out  32  head instruction word
//  misalign_pulse    out  1   one-cycle flag: a redirect_addr had bits[1:0] != 0
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
//   All outputs 0 except imem_req_addr=RESET_PC.
//  Request:
//   - imem_req_valid = (outstanding + occupancy < FQ_DEPTH).
//   - Handshake when valid && ready: pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0); outstanding++.
//  Response:
//   - On imem_rsp_valid: outstanding--.
//   - If drop_cnt>0: discard and drop_cnt--. Else push {pc_of_req, data} into the queue.
//   - The request PC travels in a parallel PC FIFO, or is recomputed as head-of-inflight PC.
//  Decode handshake:
//   - if_valid = !empty && !redirect_valid.
//   - Pop when if_valid && if_ready.
//   - Latency: request accept -> earliest if_valid is 1 cycle after rsp_valid (registered queue).
//  Redirect (highest priority):
//   - Queue flushed. pc <= {redirect_addr[31:2],2'b00}.
//   - drop_cnt <= outstanding_next, which includes any request accepted and excludes any response retired in the same cycle.
//   - misalign_pulse <= |redirect_addr[1:0].
//   - The next cycle presents the new PC on imem_req_addr.
//   - A request handshaking in the redirect cycle carries the old PC and is dropped.
//   - A response in the redirect cycle is discarded.
//  Credit rule guarantees the queue never overflows. Push on a full queue, or rsp_valid with outstanding==0, is an assertion failure.
//  Simultaneous push+pop on a full queue is legal (count unchanged).
//  Reset mid-operation: every counter is cleared. Responses to pre-reset requests are not expected (imem is reset too).
// STRUCTURE
//  fetch_pkg:
//   - RESET_PC_DEFAULT, INSTR_W=32, XLEN=32.
//   - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
//  Sub-module fetch_fifo #(type T, DEPTH):
//   - Sync FIFO with flush, push, pop, full, empty, count.
//   - Instantiated for the queue. A second instance may track in-flight PCs.
//  Top:
//   - Registers: pc, outstanding, drop_cnt, misalign_pulse.
//   - Combinational: credit compare and redirect mux.
// TESTING
//  1 Reset, ready=1, rsp one cycle after each req, if_ready=1:
//    - imem_req_addr 0,4,8,...
//    - if_pc/if_instr follow in order, one per cycle steady state.
//  2 if_ready=0, FQ_DEPTH=2:
//    - Exactly 2 requests issue, then imem_req_valid=0.
//    - Raising if_ready for one pop re-enables exactly one request.
//  3 Two requests outstanding (0x10,0x14), then redirect_valid with redirect_addr=0x100:
//    - Both responses discarded.
//    - Next request addr=0x100; first if_pc=0x100.
//  4 Redirect in the same cycle as a request handshake and a response:
//    - Handshaked request dropped; response discarded.
//    - if_valid low in the redirect cycle; queue empty afterwards.
//  5 redirect_addr=0x203:
//    - misalign_pulse=1 for one cycle.
//    - imem_req_addr=0x200.
//  6 rst_n asserted mid-stream with 2 outstanding and 1 queued:
//    - All outputs reset immediately (async).
//    - After release, first request addr=RESET_PC and no stale entries appear.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam int          XLEN             = 32;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head entry is read straight from storage.
module fetch_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: empty gates every use of a stale entry.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests and queues
// in-order responses as (pc, instr) pairs for decode, honouring redirects.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign_pulse
);

    localparam int             CW         = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0]    CREDIT_MAX = FQ_DEPTH[CW:0];

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occupancy;
    logic [CW:0]     credit_used;
    logic            active;
    logic            req_fire;
    logic            q_push;
    logic            q_pop;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    q_wdata;
    fetch_entry_t    q_head;

    assign credit_used      = {1'b0, outstanding} + {1'b0, occupancy};
    assign imem_req_valid   = active && !q_full && (credit_used < CREDIT_MAX);
    assign imem_req_addr    = pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    // Once drop_cnt is zero every in-flight request is part of the sequential
    // run ending just below pc, so the oldest one sits outstanding words back.
    assign rsp_pc  = pc - (XLEN'(outstanding) << 2);
    assign q_wdata = '{pc: rsp_pc, instr: imem_rsp_data};
    assign q_push  = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

    assign if_valid = !q_empty && !redirect_valid;
    assign q_pop    = if_valid && if_ready;
    assign if_pc    = q_empty ? '0 : q_head.pc;
    assign if_instr = q_empty ? '0 : q_head.instr;

    always_comb begin
        pc_next = pc;
        if (redirect_valid)
            pc_next = align_word(redirect_addr);
        else if (req_fire)
            pc_next = pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            outstanding    <= '0;
            drop_cnt       <= '0;
            misalign_pulse <= 1'b0;
            active         <= 1'b0;
        end else begin
            active         <= 1'b1;
            pc             <= pc_next;
            outstanding    <= outstanding_next;
            misalign_pulse <= redirect_valid && (|redirect_addr[1:0]);
            if (redirect_valid)
                drop_cnt <= outstanding_next;
            else if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (occupancy)
    );

    assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (outstanding != '0));

endmodule
